// File: rtl/bit_serializer_if.sv
// Load-side handshake bundle for bit_serializer.
//   data_in    : word to serialize (producer -> serializer)
//   load_valid : data_in valid      (producer -> serializer)
//   load_ready : serializer can take a word this cycle (serializer -> producer)
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a one-word holding buffer for gapless streaming.
// Words arrive over load_if (valid/ready) and leave one bit per clk on serial_out.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   load_if     : slave side of bit_serializer_if (data_in, load_valid, load_ready)
//   serial_out  : registered serial bit (IDLE_BIT when not streaming)
//   bit_valid   : serial_out carries a word bit
//   word_done   : high while the final bit of a word is on serial_out
//   busy        : shifting or holding buffer occupied
// Optional feature: define SER_PARITY_EN to append an even-parity bit to each word.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              n_rst,
  bit_serializer_if.slave   load_if,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              word_done,
  output logic              busy
);

`ifdef SER_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CNT_W    = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               serial_out_q, serial_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               word_done_q, word_done_d;
  logic               busy_q, busy_d;
  logic               load_ready_q, load_ready_d;
`ifdef SER_PARITY_EN
  logic               par_q, par_d;
`endif

  logic xfer;
  assign xfer = load_if.load_valid && load_ready_q;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath: load, shift, hold-buffer management
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          sh_d    = load_if.data_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SER_PARITY_EN
          par_d   = ^load_if.data_in;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          // Held word wins; load_ready is low whenever hold_full is set
          if (hold_full_q) begin
            sh_d        = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
`ifdef SER_PARITY_EN
            par_d       = ^hold_q;
`endif
          end else if (xfer) begin
            sh_d  = load_if.data_in;
            cnt_d = '0;
`ifdef SER_PARITY_EN
            par_d = ^load_if.data_in;
`endif
          end else begin
            sh_d    = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (MSB_FIRST) sh_d = {sh_q[WIDTH-2:0], 1'b0};
          else           sh_d = {1'b0, sh_q[WIDTH-1:1]};
          if (xfer) begin
            hold_d      = load_if.data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs from next-state values so they are registered yet aligned with the shift
  always_comb begin
    serial_out_d = IDLE_BIT;
    bit_valid_d  = 1'b0;
    word_done_d  = 1'b0;
    if (state_d == S_SHIFT) begin
      bit_valid_d  = 1'b1;
      serial_out_d = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
      word_done_d  = (cnt_d == LAST_CNT);
`ifdef SER_PARITY_EN
      if (cnt_d == LAST_CNT) serial_out_d = par_d;
`endif
    end
    busy_d       = (state_d == S_SHIFT) || hold_full_d;
    load_ready_d = !hold_full_d;
  end

  // Datapath and output flops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q        <= '0;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      serial_out_q <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      word_done_q  <= word_done_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
`ifdef SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign load_if.load_ready = load_ready_q;
  assign serial_out         = serial_out_q;
  assign bit_valid          = bit_valid_q;
  assign word_done          = word_done_q;
  assign busy               = busy_q;

endmodule
